mfd_response_checker: RTL and testbench
=======================================

Name: mfd_response_checker

Overview:
- Hardware self-checking sequencer for a 4-input / 2-output combinational DUT of the circuito_mfd family.
- Sweeps every input vector, waits a settle interval, samples the DUT outputs and compares them against a loadable expected-response table.
- Reports mismatch count, first failing vector and a pass flag.
- Sits opposite the combinational DUT: it drives the DUT's A..D inputs and consumes its F1/F2 outputs, so an on-chip BIST replaces a simulation-only testbench.

Parameters:
- N_IN, 4: DUT input width; sweep covers 2^N_IN vectors.
- N_OUT, 2: DUT output width ({F1,F2} ordering, F1 = MSB).
- SETTLE, 1: extra cycles each vector is held before sampling; 0 is legal.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- exp_we  input  1  expected-table write enable.
- exp_addr  input  N_IN  table address (= input vector).
- exp_data  input  N_OUT  expected DUT response for exp_addr.
- vec_out  output  N_IN  vector driven to DUT ({A,B,C,D}, A = MSB).
- dut_resp  input  N_OUT  DUT response ({F1,F2}).
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until start or rst.
- pass  output  1  done with zero mismatches.
- err_count  output  N_IN+1  mismatch count, 0..2^N_IN, never wraps.
- first_fail_vec  output  N_IN  lowest vector that mismatched.
- first_fail_valid  output  1  first_fail_vec is meaningful.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-sweep):
  - state=IDLE.
  - vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid all 0.
  - settle_cnt=0.
  - Expected table is NOT cleared; contents are retained.
- Table:
  - 2^N_IN x N_OUT registers.
  - Write at the edge when exp_we=1 and busy=0.
  - exp_we while busy=1 is ignored.
  - A write and start in the same cycle: the write lands, and the sweep uses the new value.
- States: IDLE, DRIVE, DONE.
- IDLE / DONE, start=1 at edge k:
  - state=DRIVE, busy=1, done=0, pass=0.
  - vec_out=0, settle_cnt=0.
  - err_count=0, first_fail_valid=0, first_fail_vec=0.
- DRIVE:
  - If settle_cnt<SETTLE: settle_cnt+1.
  - If settle_cnt==SETTLE (compare edge): compare dut_resp against table[vec_out] using exact bitwise inequality.
  - On mismatch: err_count+1; if first_fail_valid=0, set first_fail_vec=vec_out and first_fail_valid=1.
  - Then, if vec_out==all-ones: state=DONE, busy=0, done=1, pass=(final err_count==0), including this last compare.
  - Else: vec_out+1, settle_cnt=0.
- Timing:
  - Each vector is held for SETTLE+1 cycles.
  - The last compare, and done rising, occur at edge k+2^N_IN*(SETTLE+1).
- start while in DRIVE is ignored; a sweep cannot be restarted except via DONE or rst.
- DONE:
  - vec_out holds all-ones.
  - Result outputs are held stable until start (restart, counters cleared at that edge) or rst.
- pass is 0 whenever done=0.

Test Plan:
- Load table with the DUT's true function, SETTLE=1, start at edge k -> busy=1 for 32 cycles; done=1, pass=1, err_count=0, first_fail_valid=0 at edge k+32.
- Corrupt table entries 5 and 11, sweep -> err_count=2, first_fail_vec=5, first_fail_valid=1, pass=0.
- Invert every table entry -> err_count=16 (5'b10000, no wrap), first_fail_vec=0, pass=0.
- During sweep: pulse start and write exp_addr=3 -> sweep timing unchanged and entry 3 unchanged; after done, the same write lands and re-sweep reflects it.
- Assert rst when vec_out=7 -> next edge: all outputs 0, state IDLE; start again without reloading -> pass=1, proving the table was retained.
- SETTLE=0 instance: start -> done at edge k+16; start asserted while done=1 -> counters cleared that edge and a second sweep passes.

Source files
------------

// File: rtl/mfd_response_checker.sv
// rtl/mfd_response_checker.sv - BIST sweep/compare sequencer for a small combinational DUT
// Drives every input vector, waits SETTLE cycles, compares the response against a loadable table.
module mfd_response_checker #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              exp_we,
  input  logic [N_IN-1:0]   exp_addr,
  input  logic [N_OUT-1:0]  exp_data,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  dut_resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_out_q, vec_out_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_count_q, err_count_d;
  logic [N_IN-1:0]     first_fail_vec_q, first_fail_vec_d;
  logic                first_fail_valid_q, first_fail_valid_d;

  logic [N_OUT-1:0]    table_q [2**N_IN];
  logic                mismatch;

  // Table survives reset so a sweep can be rerun without reloading it.
  always_ff @(posedge clk) begin
    if (exp_we && !busy_q) begin
      table_q[exp_addr] <= exp_data;
    end
  end

  assign mismatch = (dut_resp != table_q[vec_out_q]);

  always_comb begin
    state_d            = state_q;
    vec_out_d          = vec_out_q;
    settle_cnt_d       = settle_cnt_q;
    busy_d             = busy_q;
    done_d             = done_q;
    pass_d             = pass_q;
    err_count_d        = err_count_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d            = S_DRIVE;
          busy_d             = 1'b1;
          done_d             = 1'b0;
          pass_d             = 1'b0;
          vec_out_d          = '0;
          settle_cnt_d       = '0;
          err_count_d        = '0;
          first_fail_vec_d   = '0;
          first_fail_valid_d = 1'b0;
        end
      end
      S_DRIVE: begin
        if (settle_cnt_q != SETTLE_C) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end else begin
          if (mismatch) begin
            err_count_d = err_count_q + (N_IN+1)'(1);
            if (!first_fail_valid_q) begin
              first_fail_vec_d   = vec_out_q;
              first_fail_valid_d = 1'b1;
            end
          end
          // pass must include the verdict of this final compare.
          if (&vec_out_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end else begin
            vec_out_d    = vec_out_q + 1'b1;
            settle_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      vec_out_q          <= '0;
      settle_cnt_q       <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      err_count_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      vec_out_q          <= vec_out_d;
      settle_cnt_q       <= settle_cnt_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      err_count_q        <= err_count_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign vec_out          = vec_out_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_mfd_response_checker.sv
// tb/tb_mfd_response_checker.sv - self-checking bench for mfd_response_checker
// Index 1 is a SETTLE=1 instance, index 0 a SETTLE=0 instance; a random truth table plays the DUT.
module tb_mfd_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start, exp_we, busy, done, pass, ffv;
  logic [3:0] exp_addr [2];
  logic [1:0] exp_data [2];
  logic [3:0] vec_out  [2];
  logic [1:0] dut_resp [2];
  logic [4:0] err_count [2];
  logic [3:0] ffvec [2];

  logic [1:0] truth [16];
  logic [1:0] shadow [2][16];
  int total, bad;

  assign dut_resp[0] = truth[vec_out[0]];
  assign dut_resp[1] = truth[vec_out[1]];

  mfd_response_checker #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .exp_we(exp_we[0]),
    .exp_addr(exp_addr[0]), .exp_data(exp_data[0]), .vec_out(vec_out[0]),
    .dut_resp(dut_resp[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .first_fail_vec(ffvec[0]), .first_fail_valid(ffv[0])
  );

  mfd_response_checker #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .exp_we(exp_we[1]),
    .exp_addr(exp_addr[1]), .exp_data(exp_data[1]), .vec_out(vec_out[1]),
    .dut_resp(dut_resp[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .first_fail_vec(ffvec[1]), .first_fail_valid(ffv[1])
  );

  function automatic int model_errs(input int inst);
    int n = 0;
    for (int v = 0; v < 16; v++) if (shadow[inst][v] !== truth[v]) n++;
    return n;
  endfunction

  function automatic int model_first(input int inst);
    for (int v = 0; v < 16; v++) if (shadow[inst][v] !== truth[v]) return v;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_truth();
    for (int v = 0; v < 16; v++) truth[v] = 2'($urandom_range(0, 3));
  endtask

  task automatic write_entry(input int inst, input int addr, input logic [1:0] data);
    logic [3:0] a;
    a = addr[3:0];
    exp_we[inst]   = 1'b1;
    exp_addr[inst] = a;
    exp_data[inst] = data;
    tick();
    exp_we[inst] = 1'b0;
    shadow[inst][addr] = data;
  endtask

  task automatic load_true(input int inst);
    for (int v = 0; v < 16; v++) write_entry(inst, v, truth[v]);
  endtask

  task automatic kick(input int inst);
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, output int cycles, output bit busy_ok);
    cycles  = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done[inst] === 1'b1) begin
        cycles = c;
        break;
      end
      if (busy[inst] !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      total++; if (vec_out[i] !== 4'd0) begin bad++; $display("FAIL rst_vec inst=%0d got=%0d want=0", i, vec_out[i]); end
      total++; if (busy[i] !== 1'b0) begin bad++; $display("FAIL rst_busy inst=%0d got=%b want=0", i, busy[i]); end
      total++; if (done[i] !== 1'b0) begin bad++; $display("FAIL rst_done inst=%0d got=%b want=0", i, done[i]); end
      total++; if (pass[i] !== 1'b0) begin bad++; $display("FAIL rst_pass inst=%0d got=%b want=0", i, pass[i]); end
      total++; if (err_count[i] !== 5'd0) begin bad++; $display("FAIL rst_err inst=%0d got=%0d want=0", i, err_count[i]); end
      total++; if ({ffv[i], ffvec[i]} !== 5'd0) begin bad++; $display("FAIL rst_first inst=%0d got=%b/%0d want=0/0", i, ffv[i], ffvec[i]); end
    end
  endtask

  task automatic test_true_table();
    int cyc; bit bok;
    load_true(1);
    kick(1);
    total++; if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin bad++; $display("FAIL true_start got=%b%b want=10", busy[1], done[1]); end
    wait_done(1, cyc, bok);
    total++; if (cyc !== 32) begin bad++; $display("FAIL true_cycles got=%0d want=32", cyc); end
    total++; if (!bok || busy[1] !== 1'b0) begin bad++; $display("FAIL true_busy got=%b/%b want=1/0", bok, busy[1]); end
    total++; if (pass[1] !== 1'b1 || err_count[1] !== 5'd0) begin bad++; $display("FAIL true_pass got=%b/%0d want=1/0", pass[1], err_count[1]); end
    total++; if (ffv[1] !== 1'b0) begin bad++; $display("FAIL true_ffv got=%b want=0", ffv[1]); end
    total++; if (vec_out[1] !== 4'hF) begin bad++; $display("FAIL true_vec_hold got=%0d want=15", vec_out[1]); end
  endtask

  task automatic test_corrupt();
    int cyc; bit bok;
    write_entry(1, 5, truth[5] ^ 2'($urandom_range(1, 3)));
    write_entry(1, 11, truth[11] ^ 2'($urandom_range(1, 3)));
    kick(1);
    wait_done(1, cyc, bok);
    total++; if (err_count[1] !== 5'(model_errs(1))) begin bad++; $display("FAIL corrupt_err got=%0d want=%0d", err_count[1], model_errs(1)); end
    total++; if (ffvec[1] !== 4'(model_first(1)) || ffv[1] !== 1'b1) begin bad++; $display("FAIL corrupt_first got=%b/%0d want=1/%0d", ffv[1], ffvec[1], model_first(1)); end
    total++; if (pass[1] !== 1'b0 || cyc !== 32) begin bad++; $display("FAIL corrupt_pass got=%b/%0d want=0/32", pass[1], cyc); end
  endtask

  task automatic test_invert();
    int cyc; bit bok;
    for (int v = 0; v < 16; v++) write_entry(1, v, ~truth[v]);
    kick(1);
    wait_done(1, cyc, bok);
    total++; if (err_count[1] !== 5'd16) begin bad++; $display("FAIL invert_err got=%0d want=16", err_count[1]); end
    total++; if (ffvec[1] !== 4'd0 || ffv[1] !== 1'b1) begin bad++; $display("FAIL invert_first got=%b/%0d want=1/0", ffv[1], ffvec[1]); end
    total++; if (pass[1] !== 1'b0) begin bad++; $display("FAIL invert_pass got=%b want=0", pass[1]); end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit bok;
    load_true(1);
    kick(1);
    for (int i = 0; i < 9; i++) tick();
    start[1] = 1'b1; exp_we[1] = 1'b1; exp_addr[1] = 4'd3; exp_data[1] = ~truth[3];
    tick();
    start[1] = 1'b0; exp_we[1] = 1'b0;
    wait_done(1, cyc, bok);
    total++; if (cyc + 10 !== 32) begin bad++; $display("FAIL ignore_cycles got=%0d want=32", cyc + 10); end
    total++; if (pass[1] !== 1'b1 || err_count[1] !== 5'(model_errs(1))) begin bad++; $display("FAIL ignore_pass got=%b/%0d want=1/%0d", pass[1], err_count[1], model_errs(1)); end
    write_entry(1, 3, ~truth[3]);
    kick(1);
    wait_done(1, cyc, bok);
    total++; if (err_count[1] !== 5'(model_errs(1))) begin bad++; $display("FAIL relanded_err got=%0d want=%0d", err_count[1], model_errs(1)); end
    total++; if (ffvec[1] !== 4'(model_first(1)) || pass[1] !== 1'b0) begin bad++; $display("FAIL relanded_first got=%0d/%b want=%0d/0", ffvec[1], pass[1], model_first(1)); end
  endtask

  task automatic test_rst_mid();
    int cyc; bit bok; bit seen;
    load_true(1);
    write_entry(1, 2, truth[2] ^ 2'b01);
    kick(1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (vec_out[1] === 4'd7) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_reach got=%0d want=7", vec_out[1]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({vec_out[1], busy[1], done[1], pass[1]} !== 7'd0) begin bad++; $display("FAIL rstmid_ctl got=%0d/%b%b%b want=0/000", vec_out[1], busy[1], done[1], pass[1]); end
    total++; if ({err_count[1], ffv[1], ffvec[1]} !== 10'd0) begin bad++; $display("FAIL rstmid_res got=%0d/%b/%0d want=0/0/0", err_count[1], ffv[1], ffvec[1]); end
    tick();
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", busy[1]); end
    kick(1);
    wait_done(1, cyc, bok);
    total++; if (err_count[1] !== 5'(model_errs(1)) || ffvec[1] !== 4'(model_first(1))) begin bad++; $display("FAIL retained got=%0d/%0d want=%0d/%0d", err_count[1], ffvec[1], model_errs(1), model_first(1)); end
    total++; if (cyc !== 32) begin bad++; $display("FAIL retained_cycles got=%0d want=32", cyc); end
  endtask

  task automatic test_settle0();
    int cyc; bit bok; int r;
    load_true(0);
    kick(0);
    wait_done(0, cyc, bok);
    total++; if (cyc !== 16 || pass[0] !== 1'b1) begin bad++; $display("FAIL s0_first got=%0d/%b want=16/1", cyc, pass[0]); end
    r = $urandom_range(0, 15);
    write_entry(0, r, ~truth[r]);
    kick(0);
    wait_done(0, cyc, bok);
    total++; if (err_count[0] !== 5'(model_errs(0)) || ffvec[0] !== 4'(r)) begin bad++; $display("FAIL s0_corrupt got=%0d/%0d want=%0d/%0d", err_count[0], ffvec[0], model_errs(0), r); end
    start[0] = 1'b1; exp_we[0] = 1'b1; exp_addr[0] = 4'(r); exp_data[0] = truth[r];
    tick();
    start[0] = 1'b0; exp_we[0] = 1'b0;
    shadow[0][r] = truth[r];
    total++; if ({busy[0], done[0], pass[0]} !== 3'b100) begin bad++; $display("FAIL s0_restart_ctl got=%b%b%b want=100", busy[0], done[0], pass[0]); end
    total++; if ({err_count[0], ffv[0], ffvec[0], vec_out[0]} !== 14'd0) begin bad++; $display("FAIL s0_restart_clr got=%0d/%b/%0d/%0d want=0", err_count[0], ffv[0], ffvec[0], vec_out[0]); end
    wait_done(0, cyc, bok);
    total++; if (cyc !== 16 || !bok) begin bad++; $display("FAIL s0_second_cycles got=%0d/%b want=16/1", cyc, bok); end
    total++; if (pass[0] !== 1'b1 || err_count[0] !== 5'd0) begin bad++; $display("FAIL s0_second_pass got=%b/%0d want=1/0", pass[0], err_count[0]); end
  endtask

  task automatic test_random();
    int cyc; bit bok; int want_e, want_f;
    for (int it = 0; it < 4; it++) begin
      new_truth();
      for (int inst = 0; inst < 2; inst++) begin
        for (int v = 0; v < 16; v++) begin
          if ($urandom_range(0, 3) == 0) write_entry(inst, v, truth[v] ^ 2'($urandom_range(1, 3)));
          else write_entry(inst, v, truth[v]);
        end
        want_e = model_errs(inst);
        want_f = model_first(inst);
        kick(inst);
        wait_done(inst, cyc, bok);
        total++; if (cyc !== 16 * (inst + 1) || !bok) begin bad++; $display("FAIL rnd_cycles inst=%0d got=%0d want=%0d", inst, cyc, 16 * (inst + 1)); end
        total++; if (err_count[inst] !== 5'(want_e)) begin bad++; $display("FAIL rnd_err inst=%0d got=%0d want=%0d", inst, err_count[inst], want_e); end
        total++; if (ffv[inst] !== (want_e != 0) || ffvec[inst] !== 4'(want_f)) begin bad++; $display("FAIL rnd_first inst=%0d got=%b/%0d want=%b/%0d", inst, ffv[inst], ffvec[inst], want_e != 0, want_f); end
        total++; if (pass[inst] !== (want_e == 0)) begin bad++; $display("FAIL rnd_pass inst=%0d got=%b want=%b", inst, pass[inst], want_e == 0); end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = '0; exp_we = '0;
    for (int i = 0; i < 2; i++) begin exp_addr[i] = '0; exp_data[i] = '0; end
    new_truth();
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_true_table();
    test_corrupt();
    test_invert();
    test_busy_ignore();
    test_rst_mid();
    test_settle0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
